addsub_sequencer: RTL and testbench

Command-driven initiator for the 16-bit combinational add/sub unit. Accepts ALU commands over a valid/ready handshake and reads operands from an internal 8×16 register file. Drives the adder's `add_sub`/`A`/`B` inputs, captures its `out`, writes the result back and returns it over a response handshake. Sits between the processor control FSM and the adder; it is the only block that drives the adder inputs.

---
 rtl/addsub_sequencer_pkg.sv | 50 +++++
 rtl/addsub_sequencer_if.sv | 35 +++
 rtl/addsub_sequencer_regfile8x16.sv | 39 +++
 rtl/addsub_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_addsub_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/addsub_sequencer_pkg.sv
// addsub_pkg: shared types and constants for the add/sub command sequencer.
//   op_e      : command opcodes (ADD, SUB, LOADI, MOVE)
//   state_e   : sequencer FSM states (IDLE, EXEC, RESP)
//   DEF_DATA_W/DEF_NREGS : default datapath width and register count
//   FLAG_*    : bit positions inside the {V,N,Z} flags vector
//   calc_flags: derives {V,N,Z} from operand/result sign bits
package addsub_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREGS  = 8;
  localparam int FLAGS_W    = 3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

  typedef enum logic [1:0] {
    ADD   = 2'b00,
    SUB   = 2'b01,
    LOADI = 2'b10,
    MOVE  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  // Overflow only depends on the sign bits: for SUB the B sign is effectively inverted.
  function automatic logic [FLAGS_W-1:0] calc_flags(
    input logic is_sub,
    input logic a_msb,
    input logic b_msb,
    input logic r_msb,
    input logic r_zero
  );
    logic [FLAGS_W-1:0] f;
    f         = 3'b000;
    f[FLAG_Z] = r_zero;
    f[FLAG_N] = r_msb;
    if (is_sub) begin
      f[FLAG_V] = (a_msb != b_msb) && (r_msb != a_msb);
    end else begin
      f[FLAG_V] = (a_msb == b_msb) && (r_msb != a_msb);
    end
    return f;
  endfunction

endpackage

// File: rtl/addsub_sequencer_if.sv
// addsub_sequencer_if: command and response handshakes of the sequencer.
//   cmd_valid/cmd_ready : command handshake
//   cmd_op/dst/srca/srcb/imm : command payload
//   rsp_valid/rsp_ready : response handshake
//   rsp_data            : value written to the destination register
// master = command issuer / response consumer, slave = sequencer.
interface addsub_sequencer_if
  import addsub_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [$clog2(NREGS)-1:0] cmd_dst;
  logic [$clog2(NREGS)-1:0] cmd_srca;
  logic [$clog2(NREGS)-1:0] cmd_srcb;
  logic [DATA_W-1:0]        cmd_imm;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DATA_W-1:0]        rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/addsub_sequencer_regfile8x16.sv
// regfile8x16: NREGS x DATA_W register file for the sequencer.
//   Clock/Resetn         : clock, asynchronous active-low clear of all entries
//   we_i/waddr_i/wdata_i : synchronous write port
//   raddr_a_i/rdata_a_o  : asynchronous read port A
//   raddr_b_i/rdata_b_o  : asynchronous read port B
module regfile8x16
  import addsub_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(NREGS)-1:0] raddr_a_i,
  output logic [DATA_W-1:0]        rdata_a_o,
  input  logic [$clog2(NREGS)-1:0] raddr_b_i,
  output logic [DATA_W-1:0]        rdata_b_o
);

  logic [DATA_W-1:0] mem_q [NREGS];

  // Storage: cleared on reset, single write per cycle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/addsub_sequencer.sv
// addsub_sequencer: command-driven initiator for an external combinational
// add/sub unit. Reads operands from an internal register file, drives the
// adder, writes the result back and returns it over a response handshake.
//   Clock, Resetn        : clock, asynchronous active-low reset
//   cmd_if (slave)       : command/response handshakes and payload
//   adder_add_sub/a/b    : registered adder inputs (held outside EXEC)
//   adder_out            : adder result
//   flags                : {V,N,Z} of last ADD/SUB, only with ADDSUB_FLAGS_EN
// Optional feature macro: ADDSUB_FLAGS_EN.
module addsub_sequencer
  import addsub_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  addsub_sequencer_if.slave     cmd_if,
  output logic                  adder_add_sub,
  output logic [DATA_W-1:0]     adder_a,
  output logic [DATA_W-1:0]     adder_b,
  input  logic [DATA_W-1:0]     adder_out
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic [FLAGS_W-1:0]    flags
`endif
);

  localparam int AW = $clog2(NREGS);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [AW-1:0]     dst_q, dst_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              add_sub_q, add_sub_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              cmd_ready_q, cmd_ready_d;
`ifdef ADDSUB_FLAGS_EN
  logic [FLAGS_W-1:0] flags_q, flags_d;
`endif

  logic [DATA_W-1:0] rd_a_s;
  logic [DATA_W-1:0] rd_b_s;
  logic [DATA_W-1:0] result_s;
  logic              we_s;

  regfile8x16 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .we_i      (we_s),
    .waddr_i   (dst_q),
    .wdata_i   (result_s),
    .raddr_a_i (cmd_if.cmd_srca),
    .rdata_a_o (rd_a_s),
    .raddr_b_i (cmd_if.cmd_srcb),
    .rdata_b_o (rd_b_s)
  );

  // Result select: MOVE reuses the latched A operand, which already holds R[srca].
  always_comb begin
    result_s = adder_out;
    case (op_q)
      ADD, SUB: result_s = adder_out;
      LOADI:    result_s = imm_q;
      MOVE:     result_s = a_q;
      default:  result_s = adder_out;
    endcase
  end

  // Next-state and datapath next values; everything holds unless a state acts on it.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    imm_d       = imm_q;
    a_d         = a_q;
    b_d         = b_q;
    add_sub_d   = add_sub_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    cmd_ready_d = cmd_ready_q;
    we_s        = 1'b0;
`ifdef ADDSUB_FLAGS_EN
    flags_d     = flags_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_if.cmd_valid) begin
          op_d        = op_e'(cmd_if.cmd_op);
          dst_d       = cmd_if.cmd_dst;
          imm_d       = cmd_if.cmd_imm;
          a_d         = rd_a_s;
          b_d         = rd_b_s;
          add_sub_d   = cmd_if.cmd_op[0];
          cmd_ready_d = 1'b0;
          state_d     = EXEC;
        end else begin
          state_d     = IDLE;
        end
      end
      EXEC: begin
        // Write-back does not wait for the consumer.
        we_s        = 1'b1;
        rsp_data_d  = result_s;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
`ifdef ADDSUB_FLAGS_EN
        if ((op_q == ADD) || (op_q == SUB)) begin
          flags_d = calc_flags(op_q == SUB, a_q[DATA_W-1], b_q[DATA_W-1],
                               result_s[DATA_W-1], result_s == {DATA_W{1'b0}});
        end else begin
          flags_d = flags_q;
        end
`endif
      end
      RESP: begin
        if (cmd_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset drops any in-flight command.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      op_q        <= ADD;
      dst_q       <= {AW{1'b0}};
      imm_q       <= {DATA_W{1'b0}};
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      add_sub_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DATA_W{1'b0}};
      cmd_ready_q <= 1'b1;
`ifdef ADDSUB_FLAGS_EN
      flags_q     <= 3'b000;
`endif
    end else begin
      op_q        <= op_d;
      dst_q       <= dst_d;
      imm_q       <= imm_d;
      a_q         <= a_d;
      b_q         <= b_d;
      add_sub_q   <= add_sub_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef ADDSUB_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  assign cmd_if.cmd_ready = cmd_ready_q;
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_data  = rsp_data_q;
  assign adder_add_sub    = add_sub_q;
  assign adder_a          = a_q;
  assign adder_b          = b_q;
`ifdef ADDSUB_FLAGS_EN
  assign flags            = flags_q;
`endif

endmodule

// File: tb/tb_addsub_sequencer.sv
// Testbench for addsub_sequencer: directed command vectors with hand-computed
// results, plus backpressure and mid-EXEC reset sequences.
// Flag checks are compiled in only when ADDSUB_FLAGS_EN is defined.
module tb_addsub_sequencer;
  import addsub_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  dst;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [15:0] imm;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        eas;
    logic [15:0] ed;
    logic [2:0]  ef;
  } vec_t;

  logic        Clock;
  logic        Resetn;
  logic        adder_add_sub;
  logic [15:0] adder_a;
  logic [15:0] adder_b;
  logic [15:0] adder_out;
`ifdef ADDSUB_FLAGS_EN
  logic [2:0]  flags;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int prev_acc = 0;

  vec_t vecs [13];
  vec_t v;

  addsub_sequencer_if #(.DATA_W(16), .NREGS(8)) bus ();

  addsub_sequencer #(.DATA_W(16), .NREGS(8)) dut (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .cmd_if        (bus.slave),
    .adder_add_sub (adder_add_sub),
    .adder_a       (adder_a),
    .adder_b       (adder_b),
    .adder_out     (adder_out)
`ifdef ADDSUB_FLAGS_EN
    ,
    .flags         (flags)
`endif
  );

  // Behavioural model of the external combinational adder.
  assign adder_out = adder_add_sub ? (adder_a - adder_b) : (adder_a + adder_b);

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one command with rsp_ready high; starts and ends just after a falling edge.
  task automatic run_vec(input vec_t t, input string tag);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = t.op;
    bus.cmd_dst   = t.dst;
    bus.cmd_srca  = t.sa;
    bus.cmd_srcb  = t.sb;
    bus.cmd_imm   = t.imm;
    bus.rsp_ready = 1'b1;
    chk({tag, "_idle_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge Clock);
    acc_cyc = cyc;
    chk({tag, "_exec_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
    chk({tag, "_exec_rspv"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_exec_addsub"}, {31'd0, adder_add_sub}, {31'd0, t.eas});
    chk({tag, "_exec_a"}, {16'd0, adder_a}, {16'd0, t.ea});
    chk({tag, "_exec_b"}, {16'd0, adder_b}, {16'd0, t.eb});
    bus.cmd_valid = 1'b0;
    @(negedge Clock);
    chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    chk({tag, "_rsp_data"}, {16'd0, bus.rsp_data}, {16'd0, t.ed});
    chk({tag, "_rsp_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
`ifdef ADDSUB_FLAGS_EN
    chk({tag, "_flags"}, {29'd0, flags}, {29'd0, t.ef});
`endif
    @(negedge Clock);
    chk({tag, "_post_rspv"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_post_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    //          op     dst   sa    sb    imm       ea        eb        eas   ed        ef {V,N,Z}
    vecs[0]  = '{2'b10, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0000, 16'h0000, 1'b0, 16'h0005, 3'b000};
    vecs[1]  = '{2'b10, 3'd2, 3'd0, 3'd0, 16'h0003, 16'h0000, 16'h0000, 1'b0, 16'h0003, 3'b000};
    vecs[2]  = '{2'b00, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h0005, 16'h0003, 1'b0, 16'h0008, 3'b000};
    vecs[3]  = '{2'b01, 3'd4, 3'd2, 3'd1, 16'h0000, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 3'b010};
    vecs[4]  = '{2'b10, 3'd1, 3'd0, 3'd0, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 16'h7FFF, 3'b010};
    vecs[5]  = '{2'b10, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0001, 3'b010};
    vecs[6]  = '{2'b00, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 3'b110};
    vecs[7]  = '{2'b01, 3'd5, 3'd1, 3'd1, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1, 16'h0000, 3'b001};
    vecs[8]  = '{2'b11, 3'd7, 3'd4, 3'd0, 16'h0000, 16'hFFFE, 16'h0000, 1'b1, 16'hFFFE, 3'b001};
    vecs[9]  = '{2'b00, 3'd1, 3'd1, 3'd2, 16'h0000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 3'b110};
    vecs[10] = '{2'b00, 3'd2, 3'd1, 3'd1, 16'h0000, 16'h8000, 16'h8000, 1'b0, 16'h0000, 3'b101};
    vecs[11] = '{2'b11, 3'd6, 3'd1, 3'd0, 16'h0000, 16'h8000, 16'h0000, 1'b1, 16'h8000, 3'b101};
    vecs[12] = '{2'b10, 3'd3, 3'd1, 3'd2, 16'hABCD, 16'h8000, 16'h0000, 1'b0, 16'hABCD, 3'b101};

    Resetn        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_dst   = 3'd0;
    bus.cmd_srca  = 3'd0;
    bus.cmd_srcb  = 3'd0;
    bus.cmd_imm   = 16'h0000;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge Clock);

    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("rst_add_sub", {31'd0, adder_add_sub}, 32'd0);
    chk("rst_adder_a", {16'd0, adder_a}, 32'd0);
    chk("rst_adder_b", {16'd0, adder_b}, 32'd0);
`ifdef ADDSUB_FLAGS_EN
    chk("rst_flags", {29'd0, flags}, 32'd0);
`endif
    Resetn = 1'b1;
    @(negedge Clock);

    // Back-to-back table with rsp_ready high: one accept every 3 cycles.
    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i > 0) begin
        chk($sformatf("vec%0d_period", i), acc_cyc - prev_acc, 32'd3);
      end
      prev_acc = acc_cyc;
    end

    // Backpressure: ADD R4=R1+R2 held in RESP for 5 cycles while a MOVE waits.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_dst   = 3'd4;
    bus.cmd_srca  = 3'd1;
    bus.cmd_srcb  = 3'd2;
    bus.cmd_imm   = 16'h0000;
    bus.rsp_ready = 1'b0;
    @(negedge Clock);
    chk("bp_exec_ready", {31'd0, bus.cmd_ready}, 32'd0);
    bus.cmd_op   = 2'b11;
    bus.cmd_dst  = 3'd5;
    bus.cmd_srca = 3'd3;
    bus.cmd_srcb = 3'd0;
    @(negedge Clock);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d_rspv", k), {31'd0, bus.rsp_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_data", k), {16'd0, bus.rsp_data}, 32'h8000);
      chk($sformatf("bp_hold%0d_ready", k), {31'd0, bus.cmd_ready}, 32'd0);
`ifdef ADDSUB_FLAGS_EN
      chk($sformatf("bp_hold%0d_flags", k), {29'd0, flags}, 32'd2);
`endif
      @(negedge Clock);
    end
    chk("bp_still_waiting", {31'd0, bus.rsp_valid}, 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge Clock);
    chk("bp_hs_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    chk("bp_hs_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge Clock);
    chk("bp_second_accepted", {31'd0, bus.cmd_ready}, 32'd0);
    chk("bp_second_a", {16'd0, adder_a}, 32'hABCD);
    bus.cmd_valid = 1'b0;
    @(negedge Clock);
    chk("bp_second_rspv", {31'd0, bus.rsp_valid}, 32'd1);
    chk("bp_second_data", {16'd0, bus.rsp_data}, 32'hABCD);
    @(negedge Clock);
    chk("bp_second_done", {31'd0, bus.rsp_valid}, 32'd0);

    // Reset during EXEC of ADD R6=R1+R2: nothing is written back.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_dst   = 3'd6;
    bus.cmd_srca  = 3'd1;
    bus.cmd_srcb  = 3'd2;
    @(negedge Clock);
    chk("rx_exec_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rx_exec_a", {16'd0, adder_a}, 32'h8000);
    Resetn        = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    chk("rx_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rx_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rx_adder_a", {16'd0, adder_a}, 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    v = '{2'b11, 3'd7, 3'd6, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b000};
    run_vec(v, "rx_move_r6");
    v = '{2'b11, 3'd5, 3'd1, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b000};
    run_vec(v, "rx_move_r1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
